// File: rtl/ps2_mouse_tx_if.sv
// rtl/ps2_mouse_tx_if.sv - movement report handshake between a report source and ps2_mouse_tx
interface ps2_mouse_tx_if;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] buttons;
    logic [9:0] delta_x;
    logic [9:0] delta_y;

    modport master (
        output move_valid,
        output buttons,
        output delta_x,
        output delta_y,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  buttons,
        input  delta_x,
        input  delta_y,
        output move_ready
    );
endinterface

// File: rtl/ps2_mouse_tx.sv
// rtl/ps2_mouse_tx.sv - device-side PS/2 mouse transmitter, one 3-byte packet per accepted report
module ps2_mouse_tx #(
    parameter int HALF_PERIOD = 2000,
    parameter int IDLE_CYCLES = 2500,
    parameter int BYTE_GAP    = 2500
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    ps2_mouse_tx_if.slave move,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe,
    output logic          busy,
    output logic          packet_sent,
    output logic          tx_aborted
);

    localparam int CNT_MAX0 = (HALF_PERIOD > IDLE_CYCLES) ? HALF_PERIOD : IDLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > BYTE_GAP) ? CNT_MAX0 : BYTE_GAP;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_SEND,
        S_GAP
    } state_t;

    typedef enum logic {
        PH_SETUP,
        PH_LOW
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    buttons_q;
    logic [9:0]    dx_q, dy_q;
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;

    logic [9:0]    x_sat, y_sat;
    logic [7:0]    tx_byte;
    logic [10:0]   frame;

    // Returns {overflow, sign, byte} with out-of-range deltas clamped to the 9-bit packet range
    function automatic logic [9:0] saturate(input logic [9:0] d);
        if (!d[9] && d[8]) begin
            return {1'b1, 1'b0, 8'hFF};
        end else if (d[9] && !d[8]) begin
            return {1'b1, 1'b1, 8'h00};
        end else begin
            return {1'b0, d[9], d[7:0]};
        end
    endfunction

    assign x_sat = saturate(dx_q);
    assign y_sat = saturate(dy_q);

    assign move.move_ready = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign ps2_clk_oe      = clk_oe_q;
    assign ps2_dat_oe      = dat_oe_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        packet_sent = 1'b0;
        tx_aborted  = 1'b0;
        tx_byte     = 8'h00;
        frame       = 11'h000;
        clk_oe_d    = 1'b0;
        dat_oe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (move.move_valid) begin
                    state_d = S_WAIT_LINE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
            end
            S_WAIT_LINE: begin
                if (clk_s2_q && dat_s2_q) begin
                    if (cnt_q == CW'(IDLE_CYCLES - 1)) begin
                        state_d = S_SEND;
                        cnt_d   = '0;
                        bit_d   = 4'd0;
                        phase_d = PH_SETUP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            S_SEND: begin
                if (cnt_q == CW'(HALF_PERIOD - 1)) begin
                    cnt_d = '0;
                    if (phase_q == PH_SETUP) begin
                        // A host holding the clock low while we have it released is an inhibit
                        if (!clk_s2_q) begin
                            tx_aborted = 1'b1;
                            idx_d      = 2'd0;
                            state_d    = S_WAIT_LINE;
                        end else begin
                            phase_d = PH_LOW;
                        end
                    end else begin
                        phase_d = PH_SETUP;
                        if (bit_q == 4'd10) begin
                            state_d = S_GAP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(BYTE_GAP - 1)) begin
                    cnt_d = '0;
                    if (idx_q < 2'd2) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_WAIT_LINE;
                    end else begin
                        packet_sent = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (idx_d)
            2'd0:    tx_byte = {y_sat[9], x_sat[9], y_sat[8], x_sat[8], 1'b1, buttons_q};
            2'd1:    tx_byte = x_sat[7:0];
            default: tx_byte = y_sat[7:0];
        endcase
        frame = {1'b1, ~^tx_byte, tx_byte, 1'b0};

        // Line drivers are registered from next state so the open-drain pins never glitch
        if (state_d == S_SEND) begin
            clk_oe_d = (phase_d == PH_LOW);
            dat_oe_d = ~frame[bit_d];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_SETUP;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            idx_q     <= 2'd0;
            buttons_q <= 3'd0;
            dx_q      <= 10'd0;
            dy_q      <= 10'd0;
            clk_s1_q  <= 1'b0;
            clk_s2_q  <= 1'b0;
            dat_s1_q  <= 1'b0;
            dat_s2_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_in;
            dat_s2_q <= dat_s1_q;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            if (state_q == S_IDLE && move.move_valid) begin
                buttons_q <= move.buttons;
                dx_q      <= move.delta_x;
                dy_q      <= move.delta_y;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// tb/tb_ps2_mouse_tx.sv - randomized and directed bench for ps2_mouse_tx with a falling-edge host model
module tb_ps2_mouse_tx;
    localparam int HP   = 4;
    localparam int IDLE = 8;
    localparam int GAP  = 8;

    logic CLOCK_50;
    logic reset;
    logic ps2_clk_oe, ps2_dat_oe, busy, packet_sent, tx_aborted;
    logic host_clk_hold, host_dat_hold;
    logic clk_line, dat_line;

    ps2_mouse_tx_if mif();

    assign clk_line = ~ps2_clk_oe & ~host_clk_hold;
    assign dat_line = ~ps2_dat_oe & ~host_dat_hold;

    ps2_mouse_tx #(.HALF_PERIOD(HP), .IDLE_CYCLES(IDLE), .BYTE_GAP(GAP)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .move        (mif.slave),
        .ps2_clk_in  (clk_line),
        .ps2_dat_in  (dat_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe),
        .busy        (busy),
        .packet_sent (packet_sent),
        .tx_aborted  (tx_aborted)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    int tests_run = 0;
    int tests_failed = 0;

    int cyc = 0, sent_cnt = 0, abort_cnt = 0, acc_cnt = 0, fall_cnt = 0;
    int sent_cyc = 0, acc_cyc = 0, last_fall_cyc = 0, prev_fall = 0, bad_period = 0;
    int hbits = 0;
    logic prev_clk = 1'b1;
    logic [10:0] shreg;
    logic [10:0] frames[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Host: collect one bit per device-driven falling clock edge, 11 bits per frame
    always @(negedge CLOCK_50) begin
        cyc++;
        if (tx_aborted) abort_cnt++;
        if (packet_sent) begin
            sent_cnt++;
            sent_cyc = cyc;
        end
        if (mif.move_valid && mif.move_ready && !reset) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
        if (reset || tx_aborted) begin
            hbits = 0;
        end else if (prev_clk && !clk_line && !host_clk_hold) begin
            fall_cnt++;
            last_fall_cyc = cyc;
            if (hbits > 0 && (cyc - prev_fall) != 2 * HP) bad_period++;
            prev_fall = cyc;
            shreg[hbits] = dat_line;
            hbits++;
            if (hbits == 11) begin
                frames.push_back(shreg);
                hbits = 0;
            end
        end
        prev_clk = clk_line;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic void ref_axis(input int d, output int byt, output int sgn, output int ovf);
        if (d > 255) begin
            byt = 255; sgn = 0; ovf = 1;
        end else if (d < -256) begin
            byt = 0; sgn = 1; ovf = 1;
        end else begin
            byt = (d + 256) % 256; sgn = (d < 0) ? 1 : 0; ovf = 0;
        end
    endfunction

    function automatic void ref_packet(input int btn, input int dx, input int dy,
                                       output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2);
        int xb, xs, xo, yb, ys, yo;
        ref_axis(dx, xb, xs, xo);
        ref_axis(dy, yb, ys, yo);
        b0 = 8'(yo * 128 + xo * 64 + ys * 32 + xs * 16 + 8 + btn);
        b1 = 8'(xb);
        b2 = 8'(yb);
    endfunction

    task automatic check_frames(input int base, input int btn, input int dx, input int dy);
        logic [7:0] e[3];
        logic [10:0] f;
        ref_packet(btn, dx, dy, e[0], e[1], e[2]);
        check_eq("frame_count", 32'(frames.size() >= base + 3), 1);
        for (int k = 0; k < 3; k++) begin
            if (frames.size() > base + k) begin
                f = frames[base + k];
                check_eq("start_bit", 32'(f[0]), 0);
                check_eq("data_byte", 32'(f[8:1]), 32'(e[k]));
                check_eq("parity_bit", 32'(f[9]), ($countones(e[k]) % 2 == 0) ? 1 : 0);
                check_eq("stop_bit", 32'(f[10]), 1);
            end
        end
    endtask

    task automatic send_report(input int btn, input int dx, input int dy);
        int a0;
        a0 = acc_cnt;
        mif.buttons    = 3'(btn);
        mif.delta_x    = 10'(dx);
        mif.delta_y    = 10'(dy);
        mif.move_valid = 1'b1;
        for (int i = 0; i < 2000 && acc_cnt == a0; i++) tick();
        mif.move_valid = 1'b0;
        check_eq("accept_timeout", 32'(acc_cnt > a0), 1);
    endtask

    task automatic wait_sent(input int target);
        for (int i = 0; i < 3000 && sent_cnt < target; i++) tick();
        check_eq("sent_timeout", 32'(sent_cnt >= target), 1);
    endtask

    task automatic run_packet(input int btn, input int dx, input int dy);
        int s0;
        frames.delete();
        s0 = sent_cnt;
        send_report(btn, dx, dy);
        wait_sent(s0 + 1);
        check_eq("busy_after", 32'(busy), 0);
        check_eq("ready_after", 32'(mif.move_ready), 1);
        tick(); tick();
        check_eq("sent_pulses", 32'(sent_cnt - s0), 1);
        check_frames(0, btn, dx, dy);
    endtask

    initial begin
        int s0, a0, ab0, f0, rel_cyc;
        reset = 1'b1;
        host_clk_hold = 1'b0;
        host_dat_hold = 1'b0;
        mif.move_valid = 1'b0;
        mif.buttons = 3'd0;
        mif.delta_x = 10'd0;
        mif.delta_y = 10'd0;
        repeat (3) tick();
        check_eq("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check_eq("rst_dat_oe", 32'(ps2_dat_oe), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_pulses", 32'(packet_sent | tx_aborted), 0);
        reset = 1'b0;
        tick();
        check_eq("rst_ready", 32'(mif.move_ready), 1);

        run_packet(1, 5, -3);
        run_packet(0, 300, 0);
        run_packet(0, -400, 511);
        run_packet(7, -256, 255);
        run_packet(2, -512, -257);
        for (int n = 0; n < 6; n++) begin
            run_packet(int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)) - 512,
                       int'($urandom_range(0, 1023)) - 512);
        end

        // Host inhibit during SETUP of byte1 bit 3
        s0 = sent_cnt;
        ab0 = abort_cnt;
        f0 = fall_cnt;
        send_report(4, 100, -100);
        for (int i = 0; i < 2000 && fall_cnt < f0 + 14; i++) tick();
        check_eq("inh_edges", 32'(fall_cnt >= f0 + 14), 1);
        for (int i = 0; i < 20 && ps2_clk_oe; i++) tick();
        host_clk_hold = 1'b1;
        for (int i = 0; i < 20 && abort_cnt == ab0; i++) tick();
        check_eq("inh_abort_seen", 32'(abort_cnt > ab0), 1);
        check_eq("inh_clk_rel", 32'(ps2_clk_oe), 0);
        check_eq("inh_dat_rel", 32'(ps2_dat_oe), 0);
        frames.delete();
        repeat (20) tick();
        host_clk_hold = 1'b0;
        wait_sent(s0 + 1);
        check_eq("inh_abort_cnt", 32'(abort_cnt - ab0), 1);
        check_frames(0, 4, 100, -100);

        // Host holds data low while idle
        frames.delete();
        s0 = sent_cnt;
        host_dat_hold = 1'b1;
        send_report(3, -7, 20);
        f0 = fall_cnt;
        repeat (50) tick();
        check_eq("rts_no_edges", 32'(fall_cnt - f0), 0);
        host_dat_hold = 1'b0;
        rel_cyc = cyc;
        for (int i = 0; i < 200 && fall_cnt == f0; i++) tick();
        check_eq("rts_edge_seen", 32'(fall_cnt > f0), 1);
        check_eq("rts_gap", 32'((last_fall_cyc - rel_cyc) >= IDLE), 1);
        wait_sent(s0 + 1);
        check_frames(0, 3, -7, 20);

        // Reset mid-byte0
        s0 = sent_cnt;
        ab0 = abort_cnt;
        f0 = fall_cnt;
        send_report(1, 1, 1);
        for (int i = 0; i < 500 && fall_cnt < f0 + 3; i++) tick();
        reset = 1'b1;
        tick();
        check_eq("mid_rst_clk_oe", 32'(ps2_clk_oe), 0);
        check_eq("mid_rst_dat_oe", 32'(ps2_dat_oe), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_ready", 32'(mif.move_ready), 1);
        reset = 1'b0;
        repeat (30) tick();
        check_eq("mid_rst_busy_later", 32'(busy), 0);
        check_eq("mid_rst_no_sent", 32'(sent_cnt - s0), 0);
        check_eq("mid_rst_no_abort", 32'(abort_cnt - ab0), 0);

        // Back-to-back with move_valid held
        frames.delete();
        s0 = sent_cnt;
        a0 = acc_cnt;
        mif.buttons = 3'd1; mif.delta_x = 10'(9); mif.delta_y = 10'(-9);
        mif.move_valid = 1'b1;
        for (int i = 0; i < 50 && acc_cnt == a0; i++) tick();
        mif.buttons = 3'd2; mif.delta_x = 10'(-30); mif.delta_y = 10'(400);
        for (int i = 0; i < 3000 && acc_cnt < a0 + 2; i++) tick();
        mif.move_valid = 1'b0;
        check_eq("b2b_second_acc", 32'(acc_cnt - a0), 2);
        check_eq("b2b_acc_delay", 32'(acc_cyc - sent_cyc), 1);
        wait_sent(s0 + 2);
        check_frames(0, 1, 9, -9);
        check_frames(3, 2, -30, 400);

        check_eq("clk_period", 32'(bad_period), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_tx.md
# ps2_mouse_tx

Device-side PS/2 mouse transmitter: accepts one movement report (buttons plus signed X/Y deltas) per handshake, encodes it as a standard 3-byte PS/2 mouse packet, and clocks it out on open-drain PS/2 clock/data lines as the device. It is the counterpart of the host-side PS/2 controller and mouse parser used by the canvas top level. It serves two purposes:
- loopback and hardware-in-the-loop testing of the cursor/drawing path without a physical mouse;
- driving a second board's PS/2 port.

## Interface
Parameters:
- HALF_PERIOD, 2000: CLOCK_50 cycles per PS/2 clock half-period (2000 gives 12.5 kHz).
- IDLE_CYCLES, 2500: consecutive cycles both lines must read high before a byte may start.
- BYTE_GAP, 2500: idle cycles between bytes of one packet.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- move_valid  in  1  report available.
- move_ready  out  1  block can accept a report.
- buttons  in  3  [0]=left, [1]=right, [2]=middle.
- delta_x  in  10  signed two's-complement X movement, range -512..511.
- delta_y  in  10  signed two's-complement Y movement, PS/2 convention (positive = up), no inversion.
- ps2_clk_in  in  1  sampled PS2_CLK line level.
- ps2_dat_in  in  1  sampled PS2_DAT line level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.
- busy  out  1  packet in progress.
- packet_sent  out  1  one-cycle pulse when a packet has completed.
- tx_aborted  out  1  one-cycle pulse when host inhibit aborts a packet.

## Operation
- Input synchronisation: ps2_clk_in and ps2_dat_in pass through 2-flop synchronisers. All line checks use the synchronised values.
- Handshake:
  - move_ready = 1 only in IDLE.
  - A report is accepted on the cycle with move_valid && move_ready. Buttons and both deltas are latched that cycle.
  - Inputs are ignored at all other times.
- Saturation, applied per axis to the latched value d:
  - d > 255: byte = 8'hFF, sign = 0, overflow = 1.
  - d < -256: byte = 8'h00, sign = 1, overflow = 1.
  - otherwise: byte = d[7:0], sign = d[9], overflow = 0.
- Packet bytes, in send order:
  - byte0 = {y_ovf, x_ovf, y_sign, x_sign, 1'b1, middle, right, left}.
  - byte1 = x byte.
  - byte2 = y byte.
- Frame: 11 bits, in order:
  - start bit 0;
  - data bits 0..7, LSB first;
  - odd parity bit (the parity bit makes the number of 1s in data+parity odd);
  - stop bit 1.
- Bit cell: two phases of HALF_PERIOD cycles each.
  - SETUP: clock released; data line = bit value (dat_oe = ~bit).
  - LOW: ps2_clk_oe = 1; data held unchanged.
  - The host samples on the falling clock edge.
- State machine:
  - IDLE → WAIT_LINE on accept. byte index = 0.
  - WAIT_LINE: counts consecutive cycles with clk && dat high. The count restarts on any low. After IDLE_CYCLES → SEND, bit 0.
  - SEND: steps through bits 0..10, SETUP then LOW for each. After the LOW phase of bit 10, both oe are released → GAP.
  - GAP: holds for BYTE_GAP cycles. Then:
    - byte index < 2: increment it → WAIT_LINE;
    - otherwise: pulse packet_sent → IDLE.
- Host inhibit: checked on the last cycle of every SETUP phase. If the synchronised clock is low (the host is holding it):
  - release both lines;
  - pulse tx_aborted;
  - reset byte index to 0 → WAIT_LINE. The whole packet is retried; the latched report is kept.
- Host request-to-send (data held low while idle): this block only waits in WAIT_LINE. It does not receive commands.
- busy = (state != IDLE).

## Timing
- Reset values:
  - ps2_clk_oe = 0, ps2_dat_oe = 0 (lines released);
  - busy = 0, packet_sent = 0, tx_aborted = 0;
  - state IDLE, so move_ready = 1 on the first cycle after reset deasserts.
- Reset asserted mid-packet: on the next edge, both lines are released and the report is discarded. No pulses are generated.
- Per byte, with lines idle: IDLE_CYCLES + 22·HALF_PERIOD + BYTE_GAP cycles, plus 2 cycles of synchroniser latency on the first wait.
- packet_sent asserts on the last GAP cycle of byte2. move_ready rises on the following cycle.
- A move_valid held through busy is accepted on the first IDLE cycle.

## Test plan
All scenarios use HALF_PERIOD=4, IDLE_CYCLES=8, BYTE_GAP=8, and a bench host model that samples data on falling clock edges.
- Left click, dx=+5, dy=-3 → received bytes 8'h29, 8'h05, 8'hFD with parity bits 0, 1, 0; stop bits all 1; one packet_sent pulse.
- dx=+300, dy=0, no buttons → 8'h48, 8'hFF, 8'h00. dx=-400, dy=+511 → 8'hD8, 8'h00, 8'hFF.
- Hold clock low externally during the SETUP phase of byte1 bit 3 → lines released within 1 cycle of the check, tx_aborted pulses once. After release, all 3 bytes resend, then packet_sent.
- Hold data low for 50 cycles while idle, then release → no clock edges driven until 8 consecutive high cycles after release.
- Reset asserted mid-byte0 → both oe = 0 the next cycle, busy = 0, move_ready = 1; no packet_sent or tx_aborted.
- Back-to-back reports, move_valid held high → second accepted exactly 1 cycle after the first packet_sent; the clock period measures 8 cycles throughout.
